johnson_seq_checker: RTL

- Receive-side monitor for the 4-bit synchronous sequence counter's output bus.
- The counter steps through 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000 and back to 0000 (4-bit twisted-ring order).
- This block samples the bus, decodes each code to its 3-bit sequence position, locks onto the stream, and flags out-of-sequence or illegal codes with a flywheel tolerance.
- It sits beside the counter in lab top levels as its self-check.

---
 rtl/johnson_seq_checker_pkg.sv | 29 ++
 rtl/johnson_seq_checker_decode.sv | 20 ++
 rtl/johnson_seq_checker.sv | 118 +++++++++++
 3 files changed

// File: rtl/johnson_seq_checker_pkg.sv
// Shared constants and types for the twisted-ring sequence checker.
// Holds the legal code table, the FSM state encoding and the decode result layout.
package johnson_seq_checker_pkg;

    localparam int SEQ_LEN   = 8;
    localparam int CODE_W    = 4;
    localparam int IDX_W     = 3;
    localparam int ERR_CNT_W = 8;

    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

    // Position i in the counter's cycle carries SEQ_CODE[i].
    localparam logic [CODE_W-1:0] SEQ_CODE [0:SEQ_LEN-1] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0111,
        4'b1111, 4'b1110, 4'b1100, 4'b1000
    };

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    typedef struct packed {
        logic             legal;
        logic [IDX_W-1:0] idx;
    } dec_t;

endpackage

// File: rtl/johnson_seq_checker_decode.sv
// Combinational code-to-position decoder for the twisted-ring sequence.
// Illegal codes report legal=0 with idx=0.
module johnson_seq_checker_decode
    import johnson_seq_checker_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output dec_t              dec
);

    always_comb begin
        dec = '0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            if (code == SEQ_CODE[i]) begin
                dec.legal = 1'b1;
                dec.idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/johnson_seq_checker.sv
// Receive-side monitor for the 4-bit twisted-ring counter: decodes each sample,
// locks onto the stream and flags out-of-sequence codes with flywheel tolerance.
module johnson_seq_checker
    import johnson_seq_checker_pkg::*;
#(
    parameter int LOCK_COUNT = 3,
    parameter int ERR_LIMIT  = 2
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 valid,
    input  logic [CODE_W-1:0]    q,
    output logic [IDX_W-1:0]     index,
    output logic                 code_ok,
    output logic                 locked,
    output logic                 seq_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_t           state, state_n;
    logic [IDX_W-1:0] ref_idx, ref_idx_n;
    logic [2:0]       run, run_n;
    logic [2:0]       bad, bad_n;
    logic             err_hit;
    logic             step_ok;
    logic [IDX_W-1:0] ref_next;
    logic [2:0]       run_inc, bad_inc;
    dec_t             dec;

    johnson_seq_checker_decode u_decode (
        .code (q),
        .dec  (dec)
    );

    assign ref_next = ref_idx + IDX_W'(1);
    assign step_ok  = dec.legal && (dec.idx == ref_next);
    assign run_inc  = run + 3'd1;
    assign bad_inc  = bad + 3'd1;

    always_comb begin
        state_n   = state;
        ref_idx_n = ref_idx;
        run_n     = run;
        bad_n     = bad;
        err_hit   = 1'b0;
        if (valid) begin
            case (state)
                HUNT: begin
                    if (dec.legal) begin
                        state_n   = LOCKING;
                        ref_idx_n = dec.idx;
                        run_n     = 3'd0;
                    end
                end
                LOCKING: begin
                    if (step_ok) begin
                        ref_idx_n = dec.idx;
                        run_n     = run_inc;
                        if (run_inc == 3'(LOCK_COUNT)) begin
                            state_n = LOCKED;
                            bad_n   = 3'd0;
                        end
                    end else if (dec.legal) begin
                        // A legal but unexpected code restarts acquisition from itself.
                        ref_idx_n = dec.idx;
                        run_n     = 3'd0;
                    end else begin
                        state_n = HUNT;
                    end
                end
                LOCKED: begin
                    if (step_ok) begin
                        ref_idx_n = dec.idx;
                        bad_n     = 3'd0;
                    end else begin
                        // Flywheel: advance the reference as if the step had happened.
                        err_hit   = 1'b1;
                        ref_idx_n = ref_next;
                        bad_n     = bad_inc;
                        if (bad_inc == 3'(ERR_LIMIT)) begin
                            state_n = HUNT;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= HUNT;
            ref_idx   <= '0;
            run       <= '0;
            bad       <= '0;
            index     <= '0;
            code_ok   <= 1'b0;
            locked    <= 1'b0;
            seq_err   <= 1'b0;
            err_count <= '0;
        end else begin
            state   <= state_n;
            ref_idx <= ref_idx_n;
            run     <= run_n;
            bad     <= bad_n;
            locked  <= (state_n == LOCKED);
            seq_err <= err_hit;
            if (valid) begin
                index   <= dec.idx;
                code_ok <= dec.legal;
            end
            if (err_hit && (err_count != ERR_CNT_MAX)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

endmodule
